// File: rtl/delivery_pkg.sv
// Shared definitions for the delivery map engine.
//   state_t    : game state encoding, also driven straight onto the estado output
//   LFSR_TAPS  : feedback mask of the 16-bit Galois LFSR (taps 16,14,13,11)
//   lfsr_next  : one right-shifting Galois step of that LFSR
package delivery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_OVER   = 3'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/delivery_row_gen.sv
// New-row generator for the scrolling map.
// Holds the LFSR and builds the row that enters the top of the map on a scroll.
// Ports:
//   clock, reset   : clock, asynchronous active-low reset (LFSR <= SEED)
//   step           : a scroll is happening this cycle; LFSR advances once
//   load_en        : use load_obst/load_obj instead of the LFSR pattern
//   load_obst/obj  : injected row
//   new_obst/obj   : row to shift in (combinational from the current LFSR value)
module delivery_row_gen
  import delivery_pkg::*;
#(
  parameter int          LANES = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load_en,
  input  logic [LANES-1:0] load_obst,
  input  logic [LANES-1:0] load_obj,
  output logic [LANES-1:0] new_obst,
  output logic [LANES-1:0] new_obj
);

  localparam int LB = $clog2(LANES);

  logic [15:0]   lfsr;
  logic [LB-1:0] obst_lane;
  logic [LB-1:0] obj_lane;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    lfsr <= SEED;
    else if (step) lfsr <= lfsr_next(lfsr);
  end

  // LANES is a power of two no larger than 16, so "lfsr[7:4] mod LANES"
  // is simply the low LB bits of that nibble.
  assign obst_lane = lfsr[LB-1:0];
  assign obj_lane  = lfsr[4 +: LB];

  always_comb begin
    new_obst = '0;
    new_obj  = '0;
    if (load_en) begin
      // A cell requested as both obstacle and objective becomes obstacle only.
      new_obst = load_obst;
      new_obj  = load_obj & ~load_obst;
    end else begin
      new_obst[obst_lane] = 1'b1;
      if (lfsr[15] && (obj_lane != obst_lane)) new_obj[obj_lane] = 1'b1;
    end
  end

endmodule

// File: rtl/delivery_map_engine.sv
// Delivery game map / collision datapath.
// Keeps a LANES x DEPTH map of obstacle and objective cells (row 0 is the
// player row), scrolls it every `period` cycles, applies player moves, scores
// pickups, removes lives on collisions and runs the IDLE/RUN/PAUSED/OVER FSM.
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   start, pause        : single-cycle control pulses
//   move_left/right     : single-cycle move pulses (same cycle cancels)
//   period              : cycles per scroll, latched on start (0 acts as 1)
//   row_load_*          : injected next row (test / level hook)
//   estado              : FSM state (IDLE=0, RUN=1, PAUSED=2, OVER=3)
//   player_pos, score, lives_left, game_over, win : game status
//   map_obstacle/objective : bit r*LANES+l = cell at row r, lane l
// Handshake: there is none; all control inputs are level-sampled pulses that
// act on the clock edge where they are high, and every output is a register.
module delivery_map_engine
  import delivery_pkg::*;
#(
  parameter int          LANES    = 8,
  parameter int          DEPTH    = 8,
  parameter int          SCORE_W  = 3,
  parameter int          LIVES    = 1,
  parameter int          WRAP     = 0,
  parameter int          PERIOD_W = 24,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       move_left,
  input  logic                       move_right,
  input  logic [PERIOD_W-1:0]        period,
  input  logic                       row_load_en,
  input  logic [LANES-1:0]           row_load_obst,
  input  logic [LANES-1:0]           row_load_obj,
  output logic [2:0]                 estado,
  output logic [$clog2(LANES)-1:0]   player_pos,
  output logic [SCORE_W-1:0]         score,
  output logic [2:0]                 lives_left,
  output logic                       game_over,
  output logic                       win,
  output logic [LANES*DEPTH-1:0]     map_obstacle,
  output logic [LANES*DEPTH-1:0]     map_objective
);

  localparam int                 PW        = $clog2(LANES);
  localparam int                 MW        = LANES * DEPTH;
  localparam logic [PW-1:0]      POS_MAX   = PW'(LANES - 1);
  localparam logic [PW-1:0]      POS_START = PW'(LANES / 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [2:0]         LIVES_INI = 3'(LIVES);

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] per_reg;

  logic                active;     // RUN and not being paused this cycle
  logic                scroll;
  logic [LANES-1:0]    new_obst;
  logic [LANES-1:0]    new_obj;
  logic [MW-1:0]       pos_mask;
  logic                hit_obst;
  logic                hit_obj;
  logic [MW-1:0]       obst_clr;
  logic [MW-1:0]       obj_clr;
  logic [MW-1:0]       obst_next;
  logic [MW-1:0]       obj_next;
  logic [PW-1:0]       pos_next;
  logic [SCORE_W-1:0]  score_next;
  logic [2:0]          lives_next;

  assign estado = state;

  // A pause pulse in RUN freezes that very cycle; the frozen work resumes
  // untouched when RUN is re-entered.
  assign active = (state == ST_RUN) && !pause;
  assign scroll = active && (cnt == per_reg - 1'b1);

  delivery_row_gen #(
    .LANES (LANES),
    .SEED  (SEED)
  ) u_row_gen (
    .clock     (clock),
    .reset     (reset),
    .step      (scroll),
    .load_en   (row_load_en),
    .load_obst (row_load_obst),
    .load_obj  (row_load_obj),
    .new_obst  (new_obst),
    .new_obj   (new_obj)
  );

  // Interaction with the player cell in row 0. The cleared map is what gets
  // shifted, so a pickup/collision coinciding with a scroll is never lost or
  // duplicated (row 0 falls off the bottom in that case anyway).
  always_comb begin
    pos_mask             = '0;
    pos_mask[player_pos] = 1'b1;
    hit_obst             = map_obstacle[player_pos];
    hit_obj              = map_objective[player_pos];
    obst_clr             = map_obstacle & ~pos_mask;
    obj_clr              = map_objective & ~pos_mask;
    obst_next            = obst_clr;
    obj_next             = obj_clr;
    if (scroll) begin
      obst_next = {new_obst, obst_clr[MW-1:LANES]};
      obj_next  = {new_obj, obj_clr[MW-1:LANES]};
    end
  end

  always_comb begin
    score_next = score;
    lives_next = lives_left;
    if (hit_obj && (score != SCORE_MAX)) score_next = score + 1'b1;
    if (hit_obst && (lives_left != 3'd0)) lives_next = lives_left - 3'd1;
  end

  always_comb begin
    pos_next = player_pos;
    if (move_right && !move_left) begin
      if (player_pos != POS_MAX) pos_next = player_pos + 1'b1;
      else if (WRAP != 0)        pos_next = '0;
    end else if (move_left && !move_right) begin
      if (player_pos != '0)      pos_next = player_pos - 1'b1;
      else if (WRAP != 0)        pos_next = POS_MAX;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      per_reg       <= PERIOD_W'(1);
      map_obstacle  <= '0;
      map_objective <= '0;
      player_pos    <= POS_START;
      score         <= '0;
      lives_left    <= LIVES_INI;
      game_over     <= 1'b0;
      win           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state         <= ST_RUN;
            cnt           <= '0;
            per_reg       <= (period == '0) ? PERIOD_W'(1) : period;
            map_obstacle  <= '0;
            map_objective <= '0;
            player_pos    <= POS_START;
            score         <= '0;
            lives_left    <= LIVES_INI;
            game_over     <= 1'b0;
            win           <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state <= ST_PAUSED;
          end else begin
            cnt           <= scroll ? '0 : cnt + 1'b1;
            map_obstacle  <= obst_next;
            map_objective <= obj_next;
            player_pos    <= pos_next;
            score         <= score_next;
            lives_left    <= lives_next;
            // Losing is checked first so a simultaneous max score still loses.
            if (lives_next == 3'd0) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
              win       <= 1'b0;
            end else if (score_next == SCORE_MAX) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
              win       <= 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (pause) state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/delivery_map_engine.md
Name: delivery_map_engine

Overview:
Parametrised successor to the delivery game map/collision datapath. Holds a LANES x DEPTH scrolling map of obstacle and objective cells, plus the player lane. It scrolls at a programmable period, generates new rows from an internal LFSR, applies player moves, detects pickups and collisions, and tracks score and lives. Sits in the game datapath between the button/velocity front-end and the display/debug outputs.

Parameters:
LANES, 8, lane count; power of 2, 2..16
DEPTH, 8, rows in the map; row 0 is the player row
SCORE_W, 3, score width; score saturates at 2^SCORE_W-1
LIVES, 1, lives per game, 1..7
WRAP, 0, 1 = lane moves wrap around; 0 = moves clamp at the edges
PERIOD_W, 24, width of the scroll period
SEED, 16'hACE1, LFSR reset seed; must be nonzero

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; starts a game from IDLE or OVER
pause  in  1  pulse; toggles RUN <-> PAUSED
move_left  in  1  pulse; move player one lane down
move_right  in  1  pulse; move player one lane up
period  in  PERIOD_W  clock cycles per scroll; latched on start
row_load_en  in  1  use row_load_* for the next generated row (test/level hook)
row_load_obst  in  LANES  injected obstacle row
row_load_obj  in  LANES  injected objective row
estado  out  3  IDLE=0, RUN=1, PAUSED=2, OVER=3
player_pos  out  $clog2(LANES)  current lane
score  out  SCORE_W  pickups collected
lives_left  out  3  remaining lives
game_over  out  1  high in OVER
win  out  1  high in OVER when the game ended on max score
map_obstacle  out  LANES*DEPTH  bit r*LANES+l = obstacle at row r, lane l
map_objective  out  LANES*DEPTH  same layout, objectives

Behaviour:
- Reset (reset=0, async): estado=IDLE; map cleared; score=0; lives_left=LIVES; player_pos=LANES/2; game_over=0; win=0; LFSR=SEED; scroll counter=0; period register=1. Reset mid-game aborts immediately to these values.
- IDLE/OVER + start: clear map, score=0, lives_left=LIVES, player_pos=LANES/2, game_over=0, win=0, counter=0, latch period (0 is treated as 1). Enter RUN next cycle. LFSR is not reseeded.
- RUN + pause -> PAUSED; PAUSED + pause -> RUN. In PAUSED the counter, map and position freeze and moves are ignored. start is ignored in RUN and PAUSED.
- Scroll counter (RUN only): increments every cycle. At count = period-1 it wraps to 0 and raises an internal scroll_tick. Period P therefore gives exactly one scroll every P cycles; the first scroll comes P cycles after entering RUN.
- On scroll_tick: row r <= row r+1 for r < DEPTH-1. Row DEPTH-1 <= new row, and the LFSR steps once (16-bit Galois, taps 16,14,13,11).
- New row generation:
  - If row_load_en=1, the new row is row_load_obst/obj; any overlapping cell is forced to obstacle only.
  - Otherwise: one obstacle at lane lfsr[log2(LANES)-1:0]. One objective at lane lfsr[7:4] mod LANES, only if lfsr[15]=1 and that lane differs from the obstacle lane.
- Moves (RUN only):
  - left and right in the same cycle cancel.
  - At the edges: clamp when WRAP=0, wrap when WRAP=1.
  - A move may coincide with a scroll; both apply.
- Interaction check, registered, every RUN cycle, on the current registered row 0 at the current player_pos. Results appear on the next edge.
  - Objective bit set: clear the bit; score+1, saturating.
  - Obstacle bit set: clear the bit; lives_left-1.
  - Cell clearing takes priority over a simultaneous scroll: the cleared value is what shifts, and a scrolled-away row 0 is discarded anyway.
- End conditions, evaluated on the updated values:
  - lives_left reaches 0: OVER, win=0.
  - score reaches max: OVER, win=1.
  - Both in the same cycle: lose wins (win=0).
- OVER: map, score and position hold; only start or reset leave it.

Decomposition:
- Shared package delivery_pkg holds the estado encoding constants (IDLE/RUN/PAUSED/OVER) and the LFSR tap mask.
- One natural sub-module: delivery_row_gen, containing the LFSR plus new-row generation and the inject mux.
- The FSM, counter, map registers and collision logic stay in the top module.

Test Plan:
- Reset then start, period=4, inject obstacle lane 7 on every scroll -> first scroll 4 cycles after RUN. After 8 scrolls map_obstacle has bit r*8+7 set for every row; player at lane 4; lives_left=1; score=0.
- LANES=8, inject objective at lane 4 only, period=2 -> once the row reaches row 0, score increments 1 cycle later and the cell clears. After 7 pickups, score=7, estado=OVER, win=1.
- Inject obstacle at lane 4, LIVES=1 -> when the row reaches row 0, lives_left=0, game_over=1, win=0 on the following edge. Further moves and scrolls are ignored.
- WRAP=0: 5 move_right pulses from lane 4 -> player_pos=7. WRAP=1: same stimulus -> player_pos=1. Left and right together -> no change.
- pause during RUN for 10 cycles -> map_obstacle, player_pos and counter unchanged. Second pause resumes, and the scroll lands P minus the elapsed count later.
- Drive reset low mid-game with score=3 -> all outputs return to reset values immediately (asynchronously). start afterwards begins a clean game.
